// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB power-up init sequencer: table markers,
// ROM entry layout and FSM state encodings.
package sccb_pkg;

   localparam logic [7:0] END_MARK       = 8'hFF;
   localparam logic [7:0] DELAY_MARK     = 8'hFE;
   localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;

   typedef struct packed {
      logic [7:0] sub_addr;
      logic [7:0] data;
   } rom_entry_t;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_FETCH  = 4'd1;
   localparam state_t ST_DECODE = 4'd2;
   localparam state_t ST_WR_REQ = 4'd3;
   localparam state_t ST_WR_REL = 4'd4;
   localparam state_t ST_RD_REQ = 4'd5;
   localparam state_t ST_RD_REL = 4'd6;
   localparam state_t ST_DELAY  = 4'd7;
   localparam state_t ST_NEXT   = 4'd8;
   localparam state_t ST_FINISH = 4'd9;
   localparam state_t ST_ERROR  = 4'd10;

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Request/response signals between the init sequencer and the CoreSCCB master.
interface sccb_init_sequencer_if;

   logic       start;
   logic       rw;
   logic [7:0] ip_addr;
   logic [7:0] sub_addr;
   logic [7:0] data_in;
   logic       done;
   logic [7:0] data_out;

   modport master (
      output start, rw, ip_addr, sub_addr, data_in,
      input  done, data_out
   );

   modport slave (
      input  start, rw, ip_addr, sub_addr, data_in,
      output done, data_out
   );

endinterface

// File: rtl/sccb_init_rom.sv
// Register table ROM, one {sub_addr, data} entry per word, read with one cycle
// of latency. Contents arrive as a flattened parameter built from the hex table.
module sccb_init_rom #(
   parameter int                    DEPTH = 256,
   parameter int                    AW    = $clog2(DEPTH),
   parameter logic [DEPTH*16-1:0]   INIT  = '1
) (
   input  logic          PCLK,
   input  logic [AW-1:0] addr,
   output logic [15:0]   data
);

   logic [15:0] mem [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_mem
      assign mem[g] = INIT[g*16 +: 16];
   end

   always_ff @(posedge PCLK) begin
      data <= mem[addr];
   end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the init table and drives CoreSCCB: one write per entry, optional
// read-back compare, ms delay and end-of-table markers.
//
//   state  | meaning
//   IDLE   | waiting for go
//   FETCH  | ROM address = index
//   DECODE | classify entry: end / delay / register write
//   WR_REQ | start high (write) until done seen
//   WR_REL | wait for done to drop
//   RD_REQ | start high (read-back) until done seen, capture data
//   RD_REL | wait for done to drop, compare read-back
//   DELAY  | count down nn ms
//   NEXT   | advance index, stop at last entry
//   FINISH | raise seq_done, drop busy
//   ERROR  | raise seq_err, record err_index, drop busy
module sccb_init_sequencer
   import sccb_pkg::*;
#(
   parameter int                          CLK_FREQ    = 10_000_000,
   parameter logic [7:0]                  DEV_ID      = DEV_ID_DEFAULT,
   parameter int                          TABLE_DEPTH = 256,
   parameter int                          TIMEOUT_CYC = 2_000_000,
   parameter int                          VERIFY      = 1,
   localparam int                         AW          = $clog2(TABLE_DEPTH),
   parameter logic [TABLE_DEPTH*16-1:0]   ROM_INIT    = '1
) (
   input  logic                 PCLK,
   input  logic                 PRESETN,
   input  logic                 go,
   output logic                 busy,
   output logic                 seq_done,
   output logic                 seq_err,
   output logic [AW-1:0]        err_index,
   sccb_init_sequencer_if.master bus
);

   localparam int          CPM     = CLK_FREQ / 1000;
   localparam int          DW      = $clog2(255 * CPM + 1);
   localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [AW-1:0] LAST  = AW'(TABLE_DEPTH - 1);
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);

   state_t        state;
   logic [AW-1:0] index;
   logic          start_q;
   logic          rw_q;
   logic [7:0]    ip_q;
   logic [7:0]    sub_q;
   logic [7:0]    wdata_q;
   logic [7:0]    rdata_q;
   logic [DW-1:0] dly_cnt;
   logic [TW-1:0] to_cnt;
   logic [15:0]   rom_data;
   rom_entry_t    entry;
   logic          to_hit;

   sccb_init_rom #(
      .DEPTH (TABLE_DEPTH),
      .AW    (AW),
      .INIT  (ROM_INIT)
   ) u_rom (
      .PCLK (PCLK),
      .addr (index),
      .data (rom_data)
   );

   assign entry  = rom_data;
   assign to_hit = (to_cnt <= TW'(1));

   assign bus.start    = start_q;
   assign bus.rw       = rw_q;
   assign bus.ip_addr  = ip_q;
   assign bus.sub_addr = sub_q;
   assign bus.data_in  = wdata_q;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state     <= ST_IDLE;
         index     <= '0;
         busy      <= 1'b0;
         seq_done  <= 1'b0;
         seq_err   <= 1'b0;
         err_index <= '0;
         start_q   <= 1'b0;
         rw_q      <= 1'b0;
         ip_q      <= '0;
         sub_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         dly_cnt   <= '0;
         to_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  seq_done <= 1'b0;
                  seq_err  <= 1'b0;
                  busy     <= 1'b1;
                  index    <= '0;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               if (entry.sub_addr == END_MARK && entry.data == END_MARK) begin
                  state <= ST_FINISH;
               end else if (entry.sub_addr == DELAY_MARK) begin
                  dly_cnt <= DW'(entry.data) * DW'(CPM);
                  state   <= (entry.data == 8'd0) ? ST_NEXT : ST_DELAY;
               end else begin
                  sub_q   <= entry.sub_addr;
                  wdata_q <= entry.data;
                  rw_q    <= 1'b0;
                  ip_q    <= DEV_ID;
                  start_q <= 1'b1;
                  to_cnt  <= TO_LOAD;
                  state   <= ST_WR_REQ;
               end
            end
            ST_WR_REQ: begin
               if (bus.done) begin
                  start_q <= 1'b0;
                  to_cnt  <= TO_LOAD;
                  state   <= ST_WR_REL;
               end else if (to_hit) begin
                  start_q <= 1'b0;
                  state   <= ST_ERROR;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            ST_WR_REL: begin
               if (!bus.done) begin
                  if (VERIFY != 0) begin
                     rw_q    <= 1'b1;
                     ip_q    <= DEV_ID | 8'h01;
                     start_q <= 1'b1;
                     to_cnt  <= TO_LOAD;
                     state   <= ST_RD_REQ;
                  end else begin
                     state <= ST_NEXT;
                  end
               end else if (to_hit) begin
                  state <= ST_ERROR;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            ST_RD_REQ: begin
               if (bus.done) begin
                  rdata_q <= bus.data_out;
                  start_q <= 1'b0;
                  to_cnt  <= TO_LOAD;
                  state   <= ST_RD_REL;
               end else if (to_hit) begin
                  start_q <= 1'b0;
                  state   <= ST_ERROR;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            ST_RD_REL: begin
               if (!bus.done) begin
                  state <= (rdata_q != wdata_q) ? ST_ERROR : ST_NEXT;
               end else if (to_hit) begin
                  state <= ST_ERROR;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            ST_DELAY: begin
               if (dly_cnt <= DW'(1)) begin
                  state <= ST_NEXT;
               end else begin
                  dly_cnt <= dly_cnt - 1'b1;
               end
            end
            ST_NEXT: begin
               // The last entry stops the walk rather than wrapping to entry 0.
               if (index == LAST) begin
                  state <= ST_FINISH;
               end else begin
                  index <= index + 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_FINISH: begin
               seq_done <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            ST_ERROR: begin
               seq_err   <= 1'b1;
               err_index <= index;
               start_q   <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: two instances (verify / no-verify) driven by
// randomized CoreSCCB bus models and checked against a table-walk reference.
module tb_sccb_init_sequencer;
   import sccb_pkg::*;

   localparam int CLK_FREQ = 10_000;
   localparam int CPM      = CLK_FREQ / 1000;
   localparam int TO       = 100;
   localparam int DA       = 8;
   localparam int DB       = 4;
   localparam logic [7:0] DEV = 8'h42;

   // entry 0 in the low word
   localparam logic [DA*16-1:0] ROM_A = {16'h55AA, 16'hFFFF, 16'h7BC4, 16'hFE00,
                                         16'h3A5C, 16'hFE03, 16'h1101, 16'h1280};
   localparam logic [DB*16-1:0] ROM_B = {16'h2144, 16'h2033, 16'h1101, 16'h1280};

   typedef logic [25:0] txn_t;
   typedef txn_t txn_q_t[$];

   logic PCLK = 1'b0;
   logic PRESETN;
   logic go_a, go_b;
   logic busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [2:0] eidx_a;
   logic [1:0] eidx_b;

   sccb_init_sequencer_if if_a ();
   sccb_init_sequencer_if if_b ();

   sccb_init_sequencer #(
      .CLK_FREQ(CLK_FREQ), .DEV_ID(DEV), .TABLE_DEPTH(DA),
      .TIMEOUT_CYC(TO), .VERIFY(1), .ROM_INIT(ROM_A)
   ) dut_a (
      .PCLK(PCLK), .PRESETN(PRESETN), .go(go_a), .busy(busy_a),
      .seq_done(done_a), .seq_err(err_a), .err_index(eidx_a), .bus(if_a)
   );

   sccb_init_sequencer #(
      .CLK_FREQ(CLK_FREQ), .DEV_ID(DEV), .TABLE_DEPTH(DB),
      .TIMEOUT_CYC(TO), .VERIFY(0), .ROM_INIT(ROM_B)
   ) dut_b (
      .PCLK(PCLK), .PRESETN(PRESETN), .go(go_b), .busy(busy_b),
      .seq_done(done_b), .seq_err(err_b), .err_index(eidx_b), .bus(if_b)
   );

   always #5 PCLK = ~PCLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // camera / CoreSCCB models
   bit      stall_a   = 1'b0;
   int      corrupt_a = -1;
   logic [7:0] cam_a [256];
   txn_t    log_a[$];
   txn_t    log_b[$];

   initial begin : model_a
      if_a.done = 1'b0;
      if_a.data_out = 8'h00;
      forever begin
         @(negedge PCLK);
         if (if_a.start && !if_a.done && !stall_a) begin
            txn_t t0;
            t0 = {if_a.rw, if_a.ip_addr, if_a.sub_addr, if_a.data_in};
            repeat ($urandom_range(0, 4)) @(negedge PCLK);
            if (if_a.start) begin
               chk("bus_a stable", 32'({if_a.rw, if_a.ip_addr, if_a.sub_addr, if_a.data_in}), 32'(t0));
               log_a.push_back(t0);
               if (if_a.rw)
                  if_a.data_out = (int'(if_a.sub_addr) == corrupt_a) ? ~cam_a[if_a.sub_addr]
                                                                     : cam_a[if_a.sub_addr];
               else
                  cam_a[if_a.sub_addr] = if_a.data_in;
               if_a.done = 1'b1;
               for (int k = 0; k < 50 && if_a.start; k++) @(negedge PCLK);
               repeat ($urandom_range(0, 3)) @(negedge PCLK);
               if_a.done = 1'b0;
            end
         end
      end
   end

   initial begin : model_b
      if_b.done = 1'b0;
      if_b.data_out = 8'h00;
      forever begin
         @(negedge PCLK);
         if (if_b.start && !if_b.done) begin
            repeat ($urandom_range(0, 4)) @(negedge PCLK);
            if (if_b.start) begin
               log_b.push_back({if_b.rw, if_b.ip_addr, if_b.sub_addr, if_b.data_in});
               if_b.done = 1'b1;
               for (int k = 0; k < 50 && if_b.start; k++) @(negedge PCLK);
               repeat ($urandom_range(0, 3)) @(negedge PCLK);
               if_b.done = 1'b0;
            end
         end
      end
   end

   // busy cycles with no handshake activity: fixed per-entry overhead plus delays
   int quiet_a = 0, quiet_b = 0, starthi_a = 0;
   always @(posedge PCLK) begin
      #1;
      if (busy_a && !if_a.start && !if_a.done) quiet_a++;
      if (if_a.start) starthi_a++;
      if (busy_b && !if_b.start && !if_b.done) quiet_b++;
   end

   // reference: walk the table, list expected bus transactions and outcome
   txn_t exp_q[$];
   bit   exp_done, exp_err;
   int   exp_idx, exp_quiet;

   task automatic ref_run(input logic [127:0] rom, input int depth, input bit verify,
                          input int corrupt, input bit stall);
      exp_q.delete();
      exp_done = 0; exp_err = 0; exp_idx = 0; exp_quiet = 0;
      for (int i = 0; i < depth; i++) begin
         logic [7:0] s, d;
         s = rom[i*16+8 +: 8];
         d = rom[i*16 +: 8];
         exp_quiet += 3;
         if (s == END_MARK && d == END_MARK) begin
            exp_done = 1;
            return;
         end
         if (s == DELAY_MARK) begin
            exp_quiet += int'(d) * CPM;
            continue;
         end
         if (stall) begin
            exp_err = 1; exp_idx = i;
            return;
         end
         exp_q.push_back({1'b0, DEV, s, d});
         if (verify) begin
            exp_q.push_back({1'b1, DEV | 8'h01, s, d});
            if (int'(s) == corrupt) begin
               exp_err = 1; exp_idx = i;
               return;
            end
         end
      end
      exp_quiet += 1;
      exp_done = 1;
   endtask

   task automatic cmp_run(input string tag, input txn_q_t got, input int base, input int quiet,
                          input logic sdone, input logic serr, input logic [31:0] eidx,
                          input logic start);
      chk({tag, " txn_count"}, 32'(got.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [31:0] g;
         g = (base + i < got.size()) ? 32'(got[base+i]) : 32'hFFFF_FFFF;
         chk($sformatf("%s txn%0d", tag, i), g, 32'(exp_q[i]));
      end
      chk({tag, " quiet_cycles"}, 32'(quiet), 32'(exp_quiet));
      chk({tag, " seq_done"}, 32'(sdone), 32'(exp_done));
      chk({tag, " seq_err"}, 32'(serr), 32'(exp_err));
      if (exp_err) chk({tag, " err_index"}, eidx, 32'(exp_idx));
      chk({tag, " start_low"}, 32'(start), 0);
   endtask

   task automatic run_a(input string tag, input int corrupt, input bit stall, input bit go_twice);
      int lb, q0, s0, n;
      ref_run(128'(ROM_A), DA, 1'b1, corrupt, stall);
      corrupt_a = corrupt;
      stall_a   = stall;
      lb = log_a.size(); q0 = quiet_a; s0 = starthi_a;
      @(negedge PCLK); go_a = 1'b1;
      @(negedge PCLK); go_a = 1'b0;
      n = 0;
      while (busy_a && n < 5000) begin
         @(negedge PCLK);
         go_a = go_twice && (n == 40);
         n++;
      end
      go_a = 1'b0;
      chk({tag, " terminates"}, 32'(busy_a), 0);
      cmp_run(tag, log_a, lb, quiet_a - q0, done_a, err_a, 32'(eidx_a), if_a.start);
      if (stall) chk({tag, " start_cycles"}, 32'(starthi_a - s0), TO);
   endtask

   task automatic run_b(input string tag);
      int lb, q0, n;
      ref_run(128'(ROM_B), DB, 1'b0, -1, 1'b0);
      lb = log_b.size(); q0 = quiet_b;
      @(negedge PCLK); go_b = 1'b1;
      @(negedge PCLK); go_b = 1'b0;
      n = 0;
      while (busy_b && n < 5000) begin
         @(negedge PCLK);
         n++;
      end
      chk({tag, " terminates"}, 32'(busy_b), 0);
      cmp_run(tag, log_b, lb, quiet_b - q0, done_b, err_b, 32'(eidx_b), if_b.start);
   endtask

   initial begin : main
      int pick, n;
      int wr_idx[4];
      logic [7:0] csub;
      wr_idx = '{0, 1, 3, 5};
      PRESETN = 1'b0;
      go_a = 1'b0;
      go_b = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("rst_a flags", 32'({busy_a, done_a, err_a, eidx_a}), 0);
      chk("rst_a bus", 32'({if_a.start, if_a.rw, if_a.ip_addr, if_a.sub_addr, if_a.data_in}), 0);
      chk("rst_b flags", 32'({busy_b, done_b, err_b, eidx_b}), 0);
      chk("rst_b bus", 32'({if_b.start, if_b.rw, if_b.ip_addr, if_b.sub_addr, if_b.data_in}), 0);
      PRESETN = 1'b1;
      repeat (2) @(negedge PCLK);

      run_a("verify_ok", -1, 1'b0, 1'b1);

      pick = $urandom_range(0, 3);
      csub = ROM_A[wr_idx[pick]*16+8 +: 8];
      run_a("mismatch", int'(csub), 1'b0, 1'b0);

      run_a("timeout", -1, 1'b1, 1'b0);
      stall_a = 1'b0;

      // asynchronous reset while a write request is outstanding
      corrupt_a = -1;
      @(negedge PCLK); go_a = 1'b1;
      @(negedge PCLK); go_a = 1'b0;
      n = 0;
      while (!if_a.start && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      chk("rst_mid start_seen", 32'(if_a.start), 1);
      @(posedge PCLK);
      #2 PRESETN = 1'b0;
      #1;
      chk("rst_mid start", 32'(if_a.start), 0);
      chk("rst_mid busy", 32'(busy_a), 0);
      chk("rst_mid flags", 32'({done_a, err_a}), 0);
      repeat (3) @(negedge PCLK);
      PRESETN = 1'b1;
      repeat (8) @(negedge PCLK);

      run_a("post_reset", -1, 1'b0, 1'b0);
      run_b("no_verify_last");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Sequences power-up configuration of the camera through the CoreSCCB master.
- Walks a register table (sub_addr/data pairs) stored in a sub-module ROM, issuing one SCCB write per entry.
- Optional read-back verify per entry; table entries can also encode ms delays and end-of-table.
- Sits between the APB wrapper/software kick and CoreSCCB; owns the master's start/rw/address/data inputs while busy.

Parameters:
- CLK_FREQ, 10_000_000, PCLK frequency in Hz; sets cycles per ms (CLK_FREQ/1000).
- DEV_ID, 8'h42, camera SCCB write ID; read ID = DEV_ID|1.
- TABLE_DEPTH, 256, ROM entries; address width = clog2(TABLE_DEPTH).
- TIMEOUT_CYC, 2_000_000, max cycles waiting for sccb_done per transaction.
- VERIFY, 1, 1 = read back each written register and compare.

Ports:
- PCLK in 1: system clock.
- PRESETN in 1: asynchronous active-low reset.
- go in 1: one-cycle pulse; starts the sequence from entry 0 when idle, ignored when busy.
- busy out 1: high from go accepted until FINISH/ERROR.
- seq_done out 1: sticky, set on end-of-table, cleared by next go.
- seq_err out 1: sticky, set on timeout or verify mismatch, cleared by next go.
- err_index out clog2(TABLE_DEPTH): entry index that failed.
- sccb_start out 1: start request to CoreSCCB.
- sccb_rw out 1: 0 = write, 1 = read.
- sccb_ip_addr out 8: DEV_ID or DEV_ID|1.
- sccb_sub_addr out 8: register address.
- sccb_data_in out 8: write data.
- sccb_done in 1: CoreSCCB transfer complete (level).
- sccb_data_out in 8: CoreSCCB read data.

Behaviour:
- Reset: all outputs 0; state IDLE; index 0. Reset mid-sequence aborts immediately and leaves start low. No resume.
- Table entry {sub_addr[15:8], data[7:0]}. Markers:
  - FF/FF: end of table.
  - FE/nn: delay nn ms (nn=0 means no delay).
  - All other entries: register writes.
- ROM read is synchronous with 1-cycle latency.
- States:
  - IDLE: on go, clear seq_done/seq_err, set busy, index=0 -> FETCH.
  - FETCH: present rom_addr=index -> DECODE (data valid next cycle).
  - DECODE: end marker -> FINISH; delay marker -> DELAY; else latch sub/data, rw=0, ip=DEV_ID -> WR_REQ.
  - WR_REQ: start=1 held until sccb_done=1; then start=0 -> WR_REL.
  - WR_REL: wait sccb_done=0. Then -> RD_REQ if VERIFY, else NEXT.
  - RD_REQ/RD_REL: same handshake with rw=1, ip=DEV_ID|1. Capture sccb_data_out on the cycle done is seen high. Mismatch vs data -> ERROR, else NEXT.
  - DELAY: count nn*(CLK_FREQ/1000) cycles -> NEXT.
  - NEXT: index+1. If index was TABLE_DEPTH-1 -> FINISH (no wrap), else FETCH.
  - FINISH: seq_done=1, busy=0 -> IDLE.
  - ERROR: seq_err=1, err_index=index, start=0, busy=0 -> IDLE.
- Timeout: counter cleared on entry to each REQ/REL state. Reaching TIMEOUT_CYC -> ERROR.
- Outputs sccb_* are stable for the whole of each REQ state; address/data change only in DECODE.
- go while busy is ignored. go in the same cycle as FINISH is ignored; it is only accepted in IDLE.
- Counters: delay counter width clog2(255*CLK_FREQ/1000+1); timeout counter width clog2(TIMEOUT_CYC+1). Both saturate and never wrap.

Decomposition:
- Shared package sccb_pkg: state enum, END_MARK=8'hFF, DELAY_MARK=8'hFE, default DEV_ID.
- Sub-module sccb_init_rom: synchronous ROM, initialized from a hex file, ports PCLK, addr, data[15:0].
- The sequencer holds FSM, counters and compare logic.

Test Plan:
- Table {12/80, 11/01, FF/FF}, VERIFY=0, bus model asserts done 20 cycles after start: go -> two writes (ip 42, sub 12 data 80, then sub 11 data 01), seq_done=1, busy=0, seq_err=0.
- VERIFY=1, model returns written data: each entry produces a write then a read with ip 43; seq_done=1 at end.
- VERIFY=1, model returns 00 for sub 11: seq_err=1, err_index=1, no further transactions, busy=0.
- Table {FE/03, FF/FF}, CLK_FREQ=10000: busy held 30 delay cycles (+fixed overhead), no sccb_start pulse, then seq_done=1.
- Model never asserts done, TIMEOUT_CYC=100: seq_err=1 after 100 cycles in WR_REQ, err_index=0, sccb_start=0.
- PRESETN low during WR_REQ: sccb_start=0 and busy=0 immediately (async). A second go pulse while busy causes no restart; the index sequence is unchanged.
